pool_tile_ctrl: RTL



---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_window_reduce.sv | 45 ++++
 rtl/pool_tile_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the 4x4 pooling tile sequencer.
package pool_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        POOL = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int TILE_DIM  = 4;
    localparam int RF_DEPTH  = 16;
    localparam int RF_ADDR_W = 4;

    // Top-left address of each 2x2 window, and the offsets of its four pixels.
    localparam logic [RF_ADDR_W-1:0] WIN_BASE [4] = '{4'd0, 4'd2, 4'd8, 4'd10};
    localparam logic [RF_ADDR_W-1:0] WIN_OFF  [4] = '{4'd0, 4'd1, 4'd4, 4'd5};

    function automatic logic [RF_ADDR_W-1:0] win_addr(input logic [1:0] w, input logic [1:0] r);
        return WIN_BASE[w] + WIN_OFF[r];
    endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// Window accumulator: max pooling by default, average pooling when POOL_AVG_EN is defined.
module pool_window_reduce
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  first,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] result
);

`ifdef POOL_AVG_EN
    // Two guard bits hold the sum of four pixels without overflow.
    logic [DATA_WIDTH+1:0] acc;
    logic [DATA_WIDTH+1:0] acc_next;

    always_comb begin
        acc_next = first ? {2'b00, din} : acc + {2'b00, din};
    end

    assign result = acc_next[DATA_WIDTH+1:2];
`else
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;

    // Strict compare so that ties keep the current value.
    always_comb begin
        acc_next = (first || (din > acc)) ? din : acc;
    end

    assign result = acc_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/pool_tile_ctrl.sv
// Loads a 4x4 tile into the pooling register file and streams out four 2x2 pooled results.
// Pooling mode is selected by POOL_AVG_EN (average) or its absence (max).
module pool_tile_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data0,
    input  logic [DATA_WIDTH-1:0] in_data1,
    output logic                  rf_wr,
    output logic [DATA_WIDTH-1:0] rf_in1,
    output logic [DATA_WIDTH-1:0] rf_in2,
    output logic [RF_ADDR_W-1:0]  rf_add_in1,
    output logic [RF_ADDR_W-1:0]  rf_add_in2,
    output logic [RF_ADDR_W-1:0]  rf_add_out,
    input  logic [DATA_WIDTH-1:0] rf_out1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  tile_done
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; once out_valid
    // rises, out_data is held until that transfer, and ready without valid does nothing.
    state_t                state;
    logic [2:0]            beat;
    logic [1:0]            win;
    logic [1:0]            rd;
    logic [DATA_WIDTH-1:0] result;

    assign in_ready   = (state == LOAD) && !rst;
    assign rf_wr      = in_valid && in_ready;
    assign rf_in1     = in_data0;
    assign rf_in2     = in_data1;
    assign rf_add_in1 = {beat, 1'b0};
    assign rf_add_in2 = {beat, 1'b1};
    assign rf_add_out = win_addr(win, rd);

    pool_window_reduce #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_reduce (
        .clk    (clk),
        .rst    (rst),
        .first  (rd == 2'd0),
        .en     (state == POOL),
        .din    (rf_out1),
        .result (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            beat      <= '0;
            win       <= '0;
            rd        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                LOAD: begin
                    if (rf_wr) begin
                        if (beat == 3'd7) begin
                            beat  <= '0;
                            win   <= '0;
                            rd    <= '0;
                            state <= POOL;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                POOL: begin
                    // rd wraps back to 0 after the fourth read, ready for the next window.
                    rd <= rd + 2'd1;
                    if (rd == 2'd3) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rd        <= '0;
                        if (win == 2'd3) begin
                            tile_done <= 1'b1;
                            win       <= '0;
                            beat      <= '0;
                            state     <= LOAD;
                        end else begin
                            win   <= win + 2'd1;
                            state <= POOL;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
